// File: rtl/adc_pkg.sv
// adc_pkg: shared constants, FSM encoding and format helpers for the ADC SPI capture front end
package adc_pkg;
    localparam int N_DEF          = 25;
    localparam int F_DEF          = 16;
    localparam int ADC_BITS_DEF   = 12;
    localparam int FRAME_BITS_DEF = 16;
    localparam int SCLK_DIV_DEF   = 2;
    localparam int SAMPLE_DIV_DEF = 5000;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_FORMAT = 2'd2;
    function automatic int midscale(input int bits);
        return 1 << (bits - 1);
    endfunction
    function automatic int fmt_shift(input int f, input int bits);
        return f - bits + 1;
    endfunction
    localparam int MIDSCALE = midscale(ADC_BITS_DEF);
    localparam int SHIFT    = fmt_shift(F_DEF, ADC_BITS_DEF);
endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: modulo-DIV counter with enable, sync reset and terminal-count pulse
module divisor_tick #(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == LAST);
    // count 0..DIV-1 while enabled, wrapping on the terminal count
    always_ff @(posedge i_clk)
        if (i_rst) r_cnt <= '0;
        else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/adc_spi_captura.sv
// adc_spi_captura: paces sampling, reads a serial ADC frame and emits a signed fixed-point sample
module adc_spi_captura
    import adc_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int F          = F_DEF,
    parameter int ADC_BITS   = ADC_BITS_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int SCLK_DIV   = SCLK_DIV_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Habilitar,
    input  logic         SDATA,
    output logic         SCLK,
    output logic         CS_n,
    output logic [N-1:0] Uk,
    output logic         Bandera_ADC,
    output logic         Overrun
);
    localparam int SH = fmt_shift(F, ADC_BITS);
    localparam int HW = $clog2(2 * FRAME_BITS);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * FRAME_BITS - 1);
    localparam logic [ADC_BITS:0] MID_V = (ADC_BITS + 1)'(midscale(ADC_BITS));
    logic [1:0]          r_state;
    logic [HW-1:0]       r_half;
    logic [ADC_BITS-1:0] r_shift;
    logic                r_sclk, r_cs_n, r_flag, r_ovr;
    logic [N-1:0]        r_uk;
    logic                w_sample_tick, w_sclk_tick, w_conv;
    logic [ADC_BITS:0]   w_s;
    logic [N-1:0]        w_uk;
    assign w_conv = r_state == ST_CONV;
    // only the last ADC_BITS shifted bits survive, so leading frame bits drop out naturally
    assign w_s  = {1'b0, r_shift} - MID_V;
    assign w_uk = {{(N - ADC_BITS - 1){w_s[ADC_BITS]}}, w_s} << SH;
    assign SCLK        = r_sclk;
    assign CS_n        = r_cs_n;
    assign Uk          = r_uk;
    assign Bandera_ADC = r_flag;
    assign Overrun     = r_ovr;
    divisor_tick #(.DIV(SAMPLE_DIV)) u_sample (
        .i_clk(Clk), .i_rst(Reset || !Habilitar), .i_en(Habilitar), .o_tick(w_sample_tick)
    );
    divisor_tick #(.DIV(SCLK_DIV)) u_sclk (
        .i_clk(Clk), .i_rst(Reset || !w_conv), .i_en(w_conv), .o_tick(w_sclk_tick)
    );
    // frame sequencer: start on tick, toggle SCLK each half-period, shift on rising SCLK, format once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_half  <= '0;
            r_shift <= '0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_uk    <= '0;
            r_flag  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_flag <= 1'b0;
            if (w_sample_tick && r_state != ST_IDLE) r_ovr <= 1'b1;
            if (r_state == ST_IDLE && w_sample_tick) begin
                r_state <= ST_CONV;
                r_cs_n  <= 1'b0;
                r_sclk  <= 1'b0;
                r_half  <= '0;
            end else if (w_conv && w_sclk_tick) begin
                if (!r_sclk) r_shift <= {r_shift[ADC_BITS-2:0], SDATA};
                if (r_half == LAST_HALF) begin
                    r_state <= ST_FORMAT;
                    r_cs_n  <= 1'b1;
                end else begin
                    r_half <= r_half + 1'b1;
                    r_sclk <= ~r_sclk;
                end
            end else if (r_state == ST_FORMAT) begin
                r_uk    <= w_uk;
                r_flag  <= 1'b1;
                r_state <= ST_IDLE;
            end
        end
    end
endmodule

// File: doc/adc_spi_captura.md
Name: adc_spi_captura

Overview:
- Front-end stage directly upstream of the 200 Hz low-pass filter.
- Paces the sample rate and reads one 12-bit offset-binary sample per period from a serial ADC (16-clock frame, 4 leading zeros, MSB first).
- Converts the sample to the filter's signed N-bit fixed-point format.
- Presents the result on Uk with a one-cycle Bandera_ADC strobe, ready to wire straight to the filter's Uk/Bandera_ADC inputs.

Parameters:
- N, 25: output word width; matches the filter's data width.
- F, 16: fractional bits of Uk. Q(N-F-1).F signed; ADC full scale maps to ±1.0.
- ADC_BITS, 12: ADC resolution.
- FRAME_BITS, 16: SCLK periods per conversion frame (FRAME_BITS-ADC_BITS leading bits, ignored).
- SCLK_DIV, 2: Clk cycles per SCLK half-period.
- SAMPLE_DIV, 5000: Clk cycles per sample period. Must be >= FRAME_BITS*2*SCLK_DIV+4.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- Habilitar, input, 1: sampling enable.
- SDATA, input, 1: ADC serial data.
- SCLK, output, 1: ADC serial clock; idles high.
- CS_n, output, 1: ADC chip select, active low.
- Uk, output, N: latest formatted sample, two's complement.
- Bandera_ADC, output, 1: one-Clk pulse, Uk updated this cycle.
- Overrun, output, 1: sticky flag, a sample tick arrived while a frame was still in progress.

Behaviour:
- Reset values: SCLK=1, CS_n=1, Uk=0, Bandera_ADC=0, Overrun=0. FSM=IDLE; sample counter=0; shift register=0. Reset dominates every other input in the same cycle.
- Sample timer: free-running 0..SAMPLE_DIV-1 while Habilitar=1, held at 0 while Habilitar=0. A tick occurs in the cycle the counter equals SAMPLE_DIV-1.
- IDLE:
  - Tick and Habilitar=1 -> CONV; CS_n drops the next cycle (call it cycle c).
  - Ticks while not in IDLE are dropped and set Overrun (cleared only by Reset).
- CONV:
  - Each bit period: SCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles. The first low phase starts at cycle c.
  - SDATA is shifted in (MSB first) in the Clk cycle in which SCLK goes 0->1.
  - After FRAME_BITS periods (last rising edge at c+FRAME_BITS*2*SCLK_DIV-SCLK_DIV), CS_n returns high at c+FRAME_BITS*2*SCLK_DIV (c+64 with defaults), with SCLK high. FSM -> FORMAT.
- FORMAT (1 cycle):
  - u = low ADC_BITS of the shift register; leading bits are discarded regardless of value.
  - s = u - 2^(ADC_BITS-1) as a signed (ADC_BITS+1)-bit value.
  - Uk = sign-extend(s) << (F-ADC_BITS+1), which is exact (no rounding or saturation) because F >= ADC_BITS-1.
  - FSM -> IDLE.
- Output: Uk is registered and Bandera_ADC=1 at cycle c+65 (defaults), for exactly one cycle. Uk holds until the next update.
- Habilitar falling mid-frame: the current frame completes and is delivered; no new frames start.
- Reset mid-frame: CS_n high and SCLK high next cycle; the partial sample is discarded with no Bandera_ADC.
- Habilitar rising: the first tick occurs SAMPLE_DIV cycles later.

Decomposition:
- Package adc_pkg holds:
  - FSM state encoding (IDLE, CONV, FORMAT).
  - Default widths and dividers.
  - The midscale constant 2^(ADC_BITS-1).
  - The shift amount F-ADC_BITS+1.
- One sub-module, divisor_tick: a parameterised modulo counter with enable, synchronous reset and a terminal-count pulse. It is used twice: once for the sample timer, once for the SCLK half-period.

Test Plan:
- Reset released, Habilitar=1, ADC model returns u=0xFFF -> CS_n falls after SAMPLE_DIV cycles; 16 SCLK periods of 4 Clk each; Uk=0x000FFE0, Bandera_ADC high for 1 cycle at c+65.
- u=0x000 -> Uk=0x1FF0000 (-1.0). u=0x800 -> Uk=0. u=0x7FF -> Uk=0x1FFFFE0.
- Leading 4 bits driven as 1111 with u=0x800 -> Uk=0 (leading bits ignored).
- Continuous run over 3 periods -> Bandera_ADC pulses exactly SAMPLE_DIV cycles apart. Overrun stays 0.
- Habilitar dropped at c+20 -> that frame still delivered; no further CS_n activity.
- Reset asserted at c+30 -> next cycle CS_n=1, SCLK=1, Uk=0; no Bandera_ADC pulse.
- Build with SAMPLE_DIV=60 (< frame length) -> Overrun set on the first dropped tick and remains set.
